// File: rtl/mem_write_pkg.sv
// Shared constants and helpers for the unified-memory write arbiter.
// Contents:
//   WIDTH_BYTE / WIDTH_HALF / WIDTH_WORD : legal write width codes
//   IO_STATUS_ADDR : read-only output-buffer availability register (writes discarded)
//   IO_OUT_ADDR    : flow-controlled output byte register
//   width_legal()   : true for a width code the memory understands
//   is_misaligned() : true for a half/word write not on its natural boundary
package mem_write_pkg;

   localparam logic [3:0]  WIDTH_BYTE     = 4'd1;
   localparam logic [3:0]  WIDTH_HALF     = 4'd2;
   localparam logic [3:0]  WIDTH_WORD     = 4'd4;

   localparam logic [31:0] IO_STATUS_ADDR = 32'h8000_0000;
   localparam logic [31:0] IO_OUT_ADDR    = 32'h8000_0004;

   function automatic logic width_legal(input logic [3:0] w);
      return (w == WIDTH_BYTE) || (w == WIDTH_HALF) || (w == WIDTH_WORD);
   endfunction

   function automatic logic is_misaligned(input logic [3:0] w, input logic [31:0] a);
      return ((w == WIDTH_HALF) && a[0]) || ((w == WIDTH_WORD) && (a[1:0] != 2'b00));
   endfunction

endpackage

// File: rtl/mem_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Scans the eligible mask starting at ptr, wrapping modulo NUM_REQ, and grants the
// first eligible requester. The pointer register lives in the parent.
// Ports:
//   eligible  in  NUM_REQ  requesters that may be granted this cycle
//   ptr       in  2        highest-priority requester index (< NUM_REQ)
//   grant     out NUM_REQ  one-hot grant, or zero when nothing is eligible
//   grant_idx out 2        encoded index of the granted requester
//   grant_vld out 1        any requester granted
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [1:0]         grant_idx,
   output logic               grant_vld
);

   int unsigned scan_idx;

   always_comb begin
      grant     = '0;
      grant_idx = 2'd0;
      grant_vld = 1'b0;
      scan_idx  = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         scan_idx = (32'(ptr) + off) % NUM_REQ;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && (i == scan_idx) && eligible[i]) begin
               grant[i]  = 1'b1;
               grant_idx = 2'(i);
               grant_vld = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing the unified memory's single write port.
// The winning request is registered into a one-entry stage that drives the memory
// write port for exactly one cycle; the stage drains every cycle so one write per
// cycle is sustained. Writes to IO_OUT_ADDR are throttled by io_buffer_size_avai.
// Writes to IO_STATUS_ADDR and writes with an illegal width are accepted and dropped.
// Ports:
//   clk, reset (async, active-high)
//   req_valid/req_ready : per-requester handshake (ready one-hot or zero)
//   req_addr/req_width/req_data : packed per-requester fields, requester i in slice i
//   io_buffer_size_avai : free bytes in the output buffer
//   mem_write_en/width/addr/data : registered memory write port
//   grant_id : requester owning the write in the stage
//   busy     : any request pending or stage occupied
// Optional: define MEM_WRITE_ARB_MISALIGN_CHECK_EN to drop misaligned half/word
// writes and report them on err_misaligned / err_id.
module mem_write_arbiter
   import mem_write_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter logic [31:0] IO_STATUS_ADDR = mem_write_pkg::IO_STATUS_ADDR,
   parameter logic [31:0] IO_OUT_ADDR    = mem_write_pkg::IO_OUT_ADDR
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*4-1:0]  req_width,
   input  logic [NUM_REQ*32-1:0] req_data,
   input  logic [31:0]           io_buffer_size_avai,
   output logic                  mem_write_en,
   output logic [3:0]            mem_write_width,
   output logic [31:0]           mem_addr_write,
   output logic [31:0]           mem_write_data,
   output logic [1:0]            grant_id,
`ifdef MEM_WRITE_ARB_MISALIGN_CHECK_EN
   output logic                  err_misaligned,
   output logic [1:0]            err_id,
`endif
   output logic                  busy
);

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [1:0]         win_idx;
   logic               win_vld;
   logic [31:0]        win_addr;
   logic [3:0]         win_width;
   logic [31:0]        win_data;
   logic               xfer;
   logic               discard;
   logic               stage_io;

   logic [1:0]  ptr_q, ptr_d;
   logic        vld_q, vld_d;
   logic [3:0]  width_q, width_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [1:0]  gid_q, gid_d;

   // The availability count lags one write: a byte sitting in the stage has not yet
   // been deducted, so a count of 1 is already spoken for.
   assign stage_io = vld_q && (addr_q == IO_OUT_ADDR);

   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] &&
                       !((req_addr[32*i +: 32] == IO_OUT_ADDR) &&
                         ((io_buffer_size_avai == 32'd0) ||
                          ((io_buffer_size_avai == 32'd1) && stage_io)));
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .eligible  (eligible),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (win_idx),
      .grant_vld (win_vld)
   );

   always_comb begin
      win_addr  = '0;
      win_width = '0;
      win_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_addr  = req_addr[32*i +: 32];
            win_width = req_width[4*i +: 4];
            win_data  = req_data[32*i +: 32];
         end
      end
   end

   assign req_ready = reset ? '0 : grant;
   assign xfer      = win_vld && !reset;

`ifdef MEM_WRITE_ARB_MISALIGN_CHECK_EN
   assign discard = (win_addr == IO_STATUS_ADDR) || !width_legal(win_width) ||
                    is_misaligned(win_width, win_addr);
`else
   assign discard = (win_addr == IO_STATUS_ADDR) || !width_legal(win_width);
`endif

   always_comb begin
      ptr_d   = ptr_q;
      vld_d   = xfer && !discard;
      width_d = width_q;
      addr_d  = addr_q;
      data_d  = data_q;
      gid_d   = gid_q;
      if (xfer) begin
         ptr_d = (32'(win_idx) == NUM_REQ - 1) ? 2'd0 : win_idx + 2'd1;
      end
      if (xfer && !discard) begin
         width_d = win_width;
         addr_d  = win_addr;
         data_d  = win_data;
         gid_d   = win_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q   <= 2'd0;
         vld_q   <= 1'b0;
         width_q <= 4'd0;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         gid_q   <= 2'd0;
      end else begin
         ptr_q   <= ptr_d;
         vld_q   <= vld_d;
         width_q <= width_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         gid_q   <= gid_d;
      end
   end

   assign mem_write_en    = vld_q;
   assign mem_write_width = width_q;
   assign mem_addr_write  = addr_q;
   assign mem_write_data  = data_q;
   assign grant_id        = gid_q;
   assign busy            = (|req_valid) || vld_q;

`ifdef MEM_WRITE_ARB_MISALIGN_CHECK_EN
   logic       err_q, err_d;
   logic [1:0] err_id_q, err_id_d;

   always_comb begin
      err_d    = xfer && is_misaligned(win_width, win_addr);
      err_id_d = err_d ? win_idx : err_id_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q    <= 1'b0;
         err_id_q <= 2'd0;
      end else begin
         err_q    <= err_d;
         err_id_q <= err_id_d;
      end
   end

   assign err_misaligned = err_q;
   assign err_id         = err_id_q;
`endif

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed, table-driven bench for mem_write_arbiter (NUM_REQ = 2).
// Each table row is driven after a falling edge; just before the next rising edge
// the bench compares req_ready for this cycle and the write-port outputs that the
// previous rising edge produced.
module tb_mem_write_arbiter;
   import mem_write_pkg::*;

   localparam int NR = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [NR-1:0]  req_valid;
   logic [NR-1:0]  req_ready;
   logic [NR*32-1:0] req_addr;
   logic [NR*4-1:0]  req_width;
   logic [NR*32-1:0] req_data;
   logic [31:0]    avai;
   logic           mem_write_en;
   logic [3:0]     mem_write_width;
   logic [31:0]    mem_addr_write;
   logic [31:0]    mem_write_data;
   logic [1:0]     grant_id;
   logic           busy;
`ifdef MEM_WRITE_ARB_MISALIGN_CHECK_EN
   logic           err_misaligned;
   logic [1:0]     err_id;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_write_arbiter #(
      .NUM_REQ (NR)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_addr            (req_addr),
      .req_width           (req_width),
      .req_data            (req_data),
      .io_buffer_size_avai (avai),
      .mem_write_en        (mem_write_en),
      .mem_write_width     (mem_write_width),
      .mem_addr_write      (mem_addr_write),
      .mem_write_data      (mem_write_data),
      .grant_id            (grant_id),
`ifdef MEM_WRITE_ARB_MISALIGN_CHECK_EN
      .err_misaligned      (err_misaligned),
      .err_id              (err_id),
`endif
      .busy                (busy)
   );

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] a0, a1;
      logic [3:0]  w0, w1;
      logic [31:0] d0, d1;
      logic [31:0] avai;
      logic [1:0]  exp_ready;
      logic        exp_en;
      logic [3:0]  exp_w;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      logic [1:0]  exp_gid;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] valid, input logic [31:0] a0, input logic [3:0] w0,
                      input logic [31:0] d0, input logic [31:0] a1, input logic [3:0] w1,
                      input logic [31:0] d1, input logic [31:0] av, input logic [1:0] rdy,
                      input logic en, input logic [3:0] ew, input logic [31:0] ea,
                      input logic [31:0] ed, input logic [1:0] eg);
      vec_t v;
      v.valid = valid; v.a0 = a0; v.w0 = w0; v.d0 = d0;
      v.a1 = a1; v.w1 = w1; v.d1 = d1; v.avai = av;
      v.exp_ready = rdy; v.exp_en = en; v.exp_w = ew;
      v.exp_addr = ea; v.exp_data = ed; v.exp_gid = eg;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] valid, input logic [31:0] a0, input logic [3:0] w0,
                        input logic [31:0] d0, input logic [31:0] a1, input logic [3:0] w1,
                        input logic [31:0] d1, input logic [31:0] av);
      req_valid = valid;
      req_addr  = {a1, a0};
      req_width = {w1, w0};
      req_data  = {d1, d0};
      avai      = av;
   endtask

   localparam logic [31:0] OUT = 32'h8000_0004;
   localparam logic [31:0] STS = 32'h8000_0000;

   initial begin
      // Round robin, both requesters always valid
      add(2'b11, 32'h100, 4'd4, 32'hA0, 32'h200, 4'd4, 32'hB1, 32'd8, 2'b01, 0, 4'd0, 32'h0,   32'h0,  2'd0);
      add(2'b11, 32'h100, 4'd4, 32'hA0, 32'h200, 4'd4, 32'hB1, 32'd8, 2'b10, 1, 4'd4, 32'h100, 32'hA0, 2'd0);
      add(2'b11, 32'h100, 4'd4, 32'hA0, 32'h200, 4'd4, 32'hB1, 32'd8, 2'b01, 1, 4'd4, 32'h200, 32'hB1, 2'd1);
      add(2'b11, 32'h100, 4'd4, 32'hA0, 32'h200, 4'd4, 32'hB1, 32'd8, 2'b10, 1, 4'd4, 32'h100, 32'hA0, 2'd0);
      add(2'b00, 32'h100, 4'd4, 32'hA0, 32'h200, 4'd4, 32'hB1, 32'd8, 2'b00, 1, 4'd4, 32'h200, 32'hB1, 2'd1);
      add(2'b00, 32'h100, 4'd4, 32'hA0, 32'h200, 4'd4, 32'hB1, 32'd8, 2'b00, 0, 4'd4, 32'h200, 32'hB1, 2'd1);
      // IO output register stalled on zero availability; req1 not blocked behind it
      add(2'b11, OUT,     4'd1, 32'h41, 32'h40,  4'd4, 32'hC2, 32'd0, 2'b10, 0, 4'd4, 32'h200, 32'hB1, 2'd1);
      add(2'b01, OUT,     4'd1, 32'h41, 32'h40,  4'd4, 32'hC2, 32'd0, 2'b00, 1, 4'd4, 32'h40,  32'hC2, 2'd1);
      add(2'b01, OUT,     4'd1, 32'h41, 32'h40,  4'd4, 32'hC2, 32'd2, 2'b01, 0, 4'd4, 32'h40,  32'hC2, 2'd1);
      add(2'b00, OUT,     4'd1, 32'h41, 32'h40,  4'd4, 32'hC2, 32'd2, 2'b00, 1, 4'd1, OUT,     32'h41, 2'd0);
      // avai = 1: a byte in the stage consumes the last slot
      add(2'b01, OUT,     4'd1, 32'h55, 32'h40,  4'd4, 32'hC2, 32'd1, 2'b01, 0, 4'd1, OUT,     32'h41, 2'd0);
      add(2'b01, OUT,     4'd1, 32'h66, 32'h40,  4'd4, 32'hC2, 32'd1, 2'b00, 1, 4'd1, OUT,     32'h55, 2'd0);
      add(2'b01, OUT,     4'd1, 32'h66, 32'h40,  4'd4, 32'hC2, 32'd0, 2'b00, 0, 4'd1, OUT,     32'h55, 2'd0);
      add(2'b01, OUT,     4'd1, 32'h66, 32'h40,  4'd4, 32'hC2, 32'd1, 2'b01, 0, 4'd1, OUT,     32'h55, 2'd0);
      add(2'b00, OUT,     4'd1, 32'h66, 32'h40,  4'd4, 32'hC2, 32'd1, 2'b00, 1, 4'd1, OUT,     32'h66, 2'd0);
      // Discards: status register write and width 3; pointer still advances
      add(2'b11, 32'h300, 4'd3, 32'hD0, STS,     4'd4, 32'hD1, 32'd8, 2'b10, 0, 4'd1, OUT,     32'h66, 2'd0);
      add(2'b01, 32'h300, 4'd3, 32'hD0, STS,     4'd4, 32'hD1, 32'd8, 2'b01, 0, 4'd1, OUT,     32'h66, 2'd0);
      add(2'b11, 32'h400, 4'd4, 32'hE0, 32'h500, 4'd2, 32'hE1, 32'd8, 2'b10, 0, 4'd1, OUT,     32'h66, 2'd0);
      add(2'b01, 32'h400, 4'd4, 32'hE0, 32'h500, 4'd2, 32'hE1, 32'd8, 2'b01, 1, 4'd2, 32'h500, 32'hE1, 2'd1);
      add(2'b00, 32'h400, 4'd4, 32'hE0, 32'h500, 4'd2, 32'hE1, 32'd8, 2'b00, 1, 4'd4, 32'h400, 32'hE0, 2'd0);
      add(2'b00, 32'h400, 4'd4, 32'hE0, 32'h500, 4'd2, 32'hE1, 32'd8, 2'b00, 0, 4'd4, 32'h400, 32'hE0, 2'd0);

      // Reset state, with requests pending to show ready is held low
      reset = 1'b1;
      drive(2'b11, 32'h100, 4'd4, 32'h1, 32'h200, 4'd4, 32'h2, 32'd8);
      #1;
      chk("rst_ready", 0, 32'(req_ready), 32'h0);
      chk("rst_en",    0, 32'(mem_write_en), 32'h0);
      chk("rst_width", 0, 32'(mem_write_width), 32'h0);
      chk("rst_addr",  0, mem_addr_write, 32'h0);
      chk("rst_data",  0, mem_write_data, 32'h0);
      chk("rst_gid",   0, 32'(grant_id), 32'h0);
`ifdef MEM_WRITE_ARB_MISALIGN_CHECK_EN
      chk("rst_err",   0, 32'(err_misaligned), 32'h0);
      chk("rst_errid", 0, 32'(err_id), 32'h0);
`endif
      @(negedge clk);
      reset = 1'b0;
      req_valid = 2'b00;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].valid, vecs[i].a0, vecs[i].w0, vecs[i].d0,
               vecs[i].a1, vecs[i].w1, vecs[i].d1, vecs[i].avai);
         #1;
         chk("ready", i, 32'(req_ready), 32'(vecs[i].exp_ready));
         chk("en",    i, 32'(mem_write_en), 32'(vecs[i].exp_en));
         chk("width", i, 32'(mem_write_width), 32'(vecs[i].exp_w));
         chk("addr",  i, mem_addr_write, vecs[i].exp_addr);
         chk("data",  i, mem_write_data, vecs[i].exp_data);
         chk("gid",   i, 32'(grant_id), 32'(vecs[i].exp_gid));
         chk("busy",  i, 32'(busy), 32'((|vecs[i].valid) || vecs[i].exp_en));
      end

      // Asynchronous reset mid-cycle while the stage holds a write to 0x10
      @(negedge clk);
      drive(2'b01, 32'h10, 4'd4, 32'h77, 32'h20, 4'd4, 32'h88, 32'd8);
      @(posedge clk);
      #1;
      chk("pre_rst_en",   100, 32'(mem_write_en), 32'h1);
      chk("pre_rst_data", 100, mem_write_data, 32'h77);
      drive(2'b11, 32'h30, 4'd4, 32'h99, 32'h20, 4'd4, 32'h88, 32'd8);
      #1;
      reset = 1'b1;
      #1;
      chk("async_en",    101, 32'(mem_write_en), 32'h0);
      chk("async_addr",  101, mem_addr_write, 32'h0);
      chk("async_ready", 101, 32'(req_ready), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", 102, 32'(req_ready), 32'h1);
      chk("post_rst_en",    102, 32'(mem_write_en), 32'h0);
      @(negedge clk);
      #1;
      chk("post_rst_en2",   103, 32'(mem_write_en), 32'h1);
      chk("post_rst_data",  103, mem_write_data, 32'h99);
      chk("post_rst_ready2", 103, 32'(req_ready), 32'h2);
      @(negedge clk);
      // req1's transfer at the last edge moved the pointer back to 0
      drive(2'b00, 32'h0, 4'd4, 32'h0, 32'h0, 4'd4, 32'h0, 32'd8);
      #1;
      chk("post_rst_gid", 104, 32'(grant_id), 32'h1);
      chk("post_rst_d88", 104, mem_write_data, 32'h88);

      // Half write at an odd address from requester 1
      @(negedge clk);
      drive(2'b10, 32'h0, 4'd4, 32'h0, 32'h103, 4'd2, 32'hAB, 32'd8);
      #1;
      chk("mis_ready", 105, 32'(req_ready), 32'h2);
      @(negedge clk);
      drive(2'b00, 32'h0, 4'd4, 32'h0, 32'h103, 4'd2, 32'hAB, 32'd8);
      #1;
`ifdef MEM_WRITE_ARB_MISALIGN_CHECK_EN
      chk("mis_en",    106, 32'(mem_write_en), 32'h0);
      chk("mis_err",   106, 32'(err_misaligned), 32'h1);
      chk("mis_errid", 106, 32'(err_id), 32'h1);
      chk("mis_addr",  106, mem_addr_write, 32'h20);
      @(negedge clk);
      #1;
      chk("mis_err_drop", 107, 32'(err_misaligned), 32'h0);
`else
      chk("mis_en",   106, 32'(mem_write_en), 32'h1);
      chk("mis_addr", 106, mem_addr_write, 32'h103);
      chk("mis_gid",  106, 32'(grant_id), 32'h1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
